// File: rtl/bsc_axiu_axis_packet_arbiter_pkg.sv
// ============================================================================
// Module  : bsc_axiu_axis_packet_arbiter_pkg
// Brief   : Shared FSM state encoding and AXI-Stream width constants for the
//           packet arbiter and its output skid buffer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package bsc_axiu_axis_packet_arbiter_pkg;

    // Merged stream payload widths
    localparam int DATA_WIDTH = 64;
    localparam int DEST_WIDTH = 2;

    // ARB picks the next requester, FWD streams one packet from it
    typedef enum logic [0:0] {
        ARB = 1'b0,
        FWD = 1'b1
    } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/bsc_axiu_axis_skid_buffer.sv
// ============================================================================
// Module  : bsc_axiu_axis_skid_buffer
// Brief   : Two-entry AXI-Stream skid buffer with fully registered outputs.
//           in_ready depends only on stored occupancy, so there is no
//           combinational path from out_ready back to in_ready.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module bsc_axiu_axis_skid_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             aresetn,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic             skid_valid_q, skid_valid_d;
    logic             w_push;
    logic             w_pop;

    // The skid slot is only occupied while the output slot is also occupied,
    // so "full" is simply the skid slot being in use.
    assign in_ready  = !skid_valid_q;
    assign w_push    = in_valid && !skid_valid_q;
    assign w_pop     = out_valid_q && out_ready;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;

    // Next-state: refill the output slot from skid first (oldest), else input
    always_comb begin
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;
        skid_data_d  = skid_data_q;
        skid_valid_d = skid_valid_q;
        if (w_pop || !out_valid_q) begin
            if (skid_valid_q) begin
                out_data_d   = skid_data_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (w_push) begin
                out_data_d  = in_data;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (w_push) begin
            skid_data_d  = in_data;
            skid_valid_d = 1'b1;
        end
    end

    // Storage registers; reset empties the buffer and clears the payload
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            skid_data_q  <= '0;
            skid_valid_q <= 1'b0;
        end else begin
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            skid_data_q  <= skid_data_d;
            skid_valid_q <= skid_valid_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/bsc_axiu_axis_packet_arbiter.sv
// ============================================================================
// Module  : bsc_axiu_axis_packet_arbiter
// Brief   : Round-robin, packet-granular AXI-Stream arbiter merging NUM_PORTS
//           slave streams into one master stream tagged with the source tid.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module bsc_axiu_axis_packet_arbiter
    import bsc_axiu_axis_packet_arbiter_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int ID_WIDTH  = 2
) (
    input  logic                             clk,
    input  logic                             aresetn,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]  S_AXIS_tdata,
    input  logic [NUM_PORTS*DEST_WIDTH-1:0]  S_AXIS_tdest,
    input  logic [NUM_PORTS-1:0]             S_AXIS_tlast,
    input  logic [NUM_PORTS-1:0]             S_AXIS_tvalid,
    output logic [NUM_PORTS-1:0]             S_AXIS_tready,
    output logic [DATA_WIDTH-1:0]            M_AXIS_tdata,
    output logic [DEST_WIDTH-1:0]            M_AXIS_tdest,
    output logic [ID_WIDTH-1:0]              M_AXIS_tid,
    output logic                             M_AXIS_tlast,
    output logic                             M_AXIS_tvalid,
    input  logic                             M_AXIS_tready
);

    localparam int PAY_WIDTH = DATA_WIDTH + DEST_WIDTH + ID_WIDTH + 1;

    arb_state_e            state_q, state_d;
    logic [ID_WIDTH-1:0]   grant_q, grant_d;   // also serves as last_grant
    logic [ID_WIDTH-1:0]   w_pick;
    logic                  w_any_req;
    logic [DATA_WIDTH-1:0] w_port_data [NUM_PORTS];
    logic [DEST_WIDTH-1:0] w_port_dest [NUM_PORTS];
    logic [DATA_WIDTH-1:0] w_sel_data;
    logic [DEST_WIDTH-1:0] w_sel_dest;
    logic                  w_sel_last;
    logic                  w_sel_valid;
    logic                  w_fwd_valid;
    logic                  w_buf_ready;
    logic                  w_accept;
    logic [PAY_WIDTH-1:0]  w_in_payload;
    logic [PAY_WIDTH-1:0]  w_out_payload;

    // Split the flat slave buses into per-port lanes
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
        assign w_port_data[gi] = S_AXIS_tdata[DATA_WIDTH*gi +: DATA_WIDTH];
        assign w_port_dest[gi] = S_AXIS_tdest[DEST_WIDTH*gi +: DEST_WIDTH];
    end

    assign w_sel_data   = w_port_data[grant_q];
    assign w_sel_dest   = w_port_dest[grant_q];
    assign w_sel_last   = S_AXIS_tlast[grant_q];
    assign w_sel_valid  = S_AXIS_tvalid[grant_q];
    assign w_fwd_valid  = (state_q == FWD) && w_sel_valid;
    assign w_accept     = w_fwd_valid && w_buf_ready;
    assign w_in_payload = {w_sel_data, w_sel_dest, grant_q, w_sel_last};

    // Round-robin pick: first requester scanning upward from grant_q+1.
    // Descending loop so the smallest offset is the one that sticks; the
    // just-served port is offset NUM_PORTS and therefore lowest priority.
    always_comb begin
        w_pick    = grant_q;
        w_any_req = 1'b0;
        for (int i = NUM_PORTS; i >= 1; i--) begin
            int idx;
            idx = (int'(grant_q) + i) % NUM_PORTS;
            if (S_AXIS_tvalid[ID_WIDTH'(idx)]) begin
                w_pick    = ID_WIDTH'(idx);
                w_any_req = 1'b1;
            end
        end
    end

    // FSM next-state and slave-side ready; a granted port keeps the grant
    // until its tlast beat is accepted
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        S_AXIS_tready = '0;
        case (state_q)
            ARB: begin
                if (w_any_req) begin
                    grant_d = w_pick;
                    state_d = FWD;
                end
            end
            FWD: begin
                S_AXIS_tready[grant_q] = w_buf_ready;
                if (w_accept && w_sel_last) begin
                    state_d = ARB;
                end
            end
            default: state_d = ARB;
        endcase
    end

    // State and grant registers; reset makes port 0 the first candidate
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= ARB;
            grant_q <= ID_WIDTH'(NUM_PORTS - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
        end
    end

    bsc_axiu_axis_skid_buffer #(
        .WIDTH (PAY_WIDTH)
    ) u_skid (
        .clk       (clk),
        .aresetn   (aresetn),
        .in_data   (w_in_payload),
        .in_valid  (w_fwd_valid),
        .in_ready  (w_buf_ready),
        .out_data  (w_out_payload),
        .out_valid (M_AXIS_tvalid),
        .out_ready (M_AXIS_tready)
    );

    assign {M_AXIS_tdata, M_AXIS_tdest, M_AXIS_tid, M_AXIS_tlast} = w_out_payload;

endmodule

`default_nettype wire

// File: tb/tb_bsc_axiu_axis_packet_arbiter.sv
// ============================================================================
// Module  : tb_bsc_axiu_axis_packet_arbiter
// Brief   : Self-checking bench for the AXI-Stream packet arbiter. A queue
//           based reference model predicts slave ready and master outputs
//           every cycle; directed scenarios add literal expectations.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bsc_axiu_axis_packet_arbiter;

    localparam int NP = 4;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            aresetn = 1'b0;
    logic [NP*64-1:0] S_AXIS_tdata;
    logic [NP*2-1:0]  S_AXIS_tdest;
    logic [NP-1:0]    S_AXIS_tlast;
    logic [NP-1:0]    S_AXIS_tvalid;
    logic [NP-1:0]    S_AXIS_tready;
    logic [63:0]      M_AXIS_tdata;
    logic [1:0]       M_AXIS_tdest;
    logic [IW-1:0]    M_AXIS_tid;
    logic             M_AXIS_tlast;
    logic             M_AXIS_tvalid;
    logic             M_AXIS_tready = 1'b1;

    always #5 clk = ~clk;

    bsc_axiu_axis_packet_arbiter #(.NUM_PORTS(NP), .ID_WIDTH(IW)) dut (
        .clk           (clk),
        .aresetn       (aresetn),
        .S_AXIS_tdata  (S_AXIS_tdata),
        .S_AXIS_tdest  (S_AXIS_tdest),
        .S_AXIS_tlast  (S_AXIS_tlast),
        .S_AXIS_tvalid (S_AXIS_tvalid),
        .S_AXIS_tready (S_AXIS_tready),
        .M_AXIS_tdata  (M_AXIS_tdata),
        .M_AXIS_tdest  (M_AXIS_tdest),
        .M_AXIS_tid    (M_AXIS_tid),
        .M_AXIS_tlast  (M_AXIS_tlast),
        .M_AXIS_tvalid (M_AXIS_tvalid),
        .M_AXIS_tready (M_AXIS_tready)
    );

    // Per-port source lanes, packed onto the DUT buses
    logic [63:0] src_data  [NP];
    logic [1:0]  src_dest  [NP];
    logic        src_last  [NP];
    logic        src_valid [NP];

    always_comb begin
        for (int i = 0; i < NP; i++) begin
            S_AXIS_tdata[64*i +: 64] = src_data[i];
            S_AXIS_tdest[2*i +: 2]   = src_dest[i];
            S_AXIS_tlast[i]          = src_last[i];
            S_AXIS_tvalid[i]         = src_valid[i];
        end
    end

    typedef struct packed {
        logic [63:0] data;
        logic [1:0]  dest;
        logic [1:0]  id;
        logic        last;
    } beat_t;

    typedef struct {
        beat_t b;
        int    cyc;
    } obs_t;

    beat_t mq[$];          // model of beats waiting on the master side
    bit    m_fwd = 1'b0;   // model: a packet currently owns the output
    int    m_grant = NP-1; // model: most recently granted port
    obs_t  log_q[$];       // master handshakes observed
    int    n_cmp = 0;
    int    n_bad = 0;
    int    cyc = 0;
    bit    abort = 1'b0;
    bit    rnd_ready = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: one transaction-level step per clock edge
    task automatic model_step();
        bit    pop;
        bit    push;
        beat_t nb;
        pop     = (mq.size() > 0) && M_AXIS_tready;
        push    = m_fwd && src_valid[m_grant] && (mq.size() < 2);
        nb.data = src_data[m_grant];
        nb.dest = src_dest[m_grant];
        nb.id   = 2'(m_grant);
        nb.last = src_last[m_grant];
        if (pop)  void'(mq.pop_front());
        if (push) mq.push_back(nb);
        if (!m_fwd) begin
            for (int k = 1; k <= NP; k++) begin
                int c;
                c = (m_grant + k) % NP;
                if (src_valid[c]) begin
                    m_grant = c;
                    m_fwd   = 1'b1;
                    break;
                end
            end
        end else if (push && nb.last) begin
            m_fwd = 1'b0;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge aresetn);
            if (!aresetn) begin
                mq.delete();
                m_fwd   = 1'b0;
                m_grant = NP-1;
            end else begin
                model_step();
            end
        end
    end

    // Per-cycle comparison against the model, plus master-side hold checks
    initial begin
        logic [3:0]  exp_rdy;
        bit          prev_stall;
        logic [63:0] prev_data;
        logic [1:0]  prev_id;
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_id    = '0;
        forever begin
            @(negedge clk);
            exp_rdy = (m_fwd && mq.size() < 2) ? (4'b0001 << m_grant) : 4'b0000;
            chk("s_tready", 64'(S_AXIS_tready), 64'(exp_rdy));
            chk("m_tvalid", 64'(M_AXIS_tvalid), 64'(mq.size() > 0));
            if (mq.size() > 0) begin
                chk("m_tdata", M_AXIS_tdata, mq[0].data);
                chk("m_tdest", 64'(M_AXIS_tdest), 64'(mq[0].dest));
                chk("m_tid",   64'(M_AXIS_tid),   64'(mq[0].id));
                chk("m_tlast", 64'(M_AXIS_tlast), 64'(mq[0].last));
            end
            if (prev_stall && aresetn) begin
                chk("hold_valid", 64'(M_AXIS_tvalid), 64'd1);
                chk("hold_data", M_AXIS_tdata, prev_data);
                chk("hold_id", 64'(M_AXIS_tid), 64'(prev_id));
            end
            prev_stall = aresetn && M_AXIS_tvalid && !M_AXIS_tready;
            prev_data  = M_AXIS_tdata;
            prev_id    = M_AXIS_tid;
            if (aresetn && M_AXIS_tvalid && M_AXIS_tready) begin
                obs_t o;
                o.b.data = M_AXIS_tdata;
                o.b.dest = M_AXIS_tdest;
                o.b.id   = M_AXIS_tid;
                o.b.last = M_AXIS_tlast;
                o.cyc    = cyc;
                log_q.push_back(o);
            end
        end
    end

    // Random back-pressure on the master side when enabled
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_ready) M_AXIS_tready = 1'($urandom_range(0, 1));
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present an n-beat packet on port p; each beat held until accepted.
    // Must be called 1 time unit after a rising edge.
    task automatic send_pkt(input int p, input int n, input logic [63:0] base);
        int   b;
        int   t;
        logic acc;
        b = 0;
        t = 0;
        while (b < n && !abort) begin
            src_valid[p] = 1'b1;
            src_data[p]  = base + 64'(b);
            src_dest[p]  = 2'(b);
            src_last[p]  = (b == n-1);
            @(negedge clk);
            acc = S_AXIS_tready[p];
            @(posedge clk);
            #1;
            if (acc) b++;
            t++;
            if (t > 2000) begin
                n_cmp++;
                n_bad++;
                $display("FAIL send_timeout: port %0d stuck at beat %0d of %0d", p, b, n);
                break;
            end
        end
        src_valid[p] = 1'b0;
        src_last[p]  = 1'b0;
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        abort   = 1'b0;
        for (int i = 0; i < NP; i++) begin
            src_valid[i] = 1'b0;
            src_last[i]  = 1'b0;
        end
        repeat (2) @(negedge clk);
        chk("rst_m_tvalid", 64'(M_AXIS_tvalid), 64'd0);
        chk("rst_m_tdata",  M_AXIS_tdata, 64'd0);
        chk("rst_m_tdest",  64'(M_AXIS_tdest), 64'd0);
        chk("rst_m_tid",    64'(M_AXIS_tid), 64'd0);
        chk("rst_m_tlast",  64'(M_AXIS_tlast), 64'd0);
        chk("rst_s_tready", 64'(S_AXIS_tready), 64'd0);
        @(posedge clk);
        #1;
        aresetn = 1'b1;
        log_q.delete();
    endtask

    // Compare the observed master log against an expected (id, data, last) list
    task automatic chk_log(input string tag, input int ids[$], input logic [63:0] dat[$], input int lasts[$]);
        chk({tag, "_count"}, 64'(log_q.size()), 64'(ids.size()));
        for (int i = 0; i < ids.size() && i < log_q.size(); i++) begin
            chk({tag, "_tid"},   64'(log_q[i].b.id), 64'(ids[i]));
            chk({tag, "_tdata"}, log_q[i].b.data, dat[i]);
            chk({tag, "_tlast"}, 64'(log_q[i].b.last), 64'(lasts[i]));
        end
    endtask

    initial begin
        int t0;
        int w;
        for (int i = 0; i < NP; i++) begin
            src_data[i]  = '0;
            src_dest[i]  = '0;
            src_last[i]  = 1'b0;
            src_valid[i] = 1'b0;
        end

        // Single 3-beat packet from port 0, latency 2 from tvalid rise
        do_reset();
        t0 = cyc;
        send_pkt(0, 3, 64'h1000);
        wait_cyc(4);
        chk_log("p0_3beat", '{0, 0, 0}, '{64'h1000, 64'h1001, 64'h1002}, '{0, 0, 1});
        if (log_q.size() > 0) chk("p0_latency", 64'(log_q[0].cyc - t0), 64'd2);

        // All four ports requesting: grants 0,1,2,3,0 with one bubble between
        do_reset();
        fork
            begin send_pkt(0, 2, 64'h2000); send_pkt(0, 2, 64'h2100); end
            send_pkt(1, 2, 64'h2200);
            send_pkt(2, 2, 64'h2300);
            send_pkt(3, 2, 64'h2400);
        join
        wait_cyc(4);
        chk_log("rr", '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0},
                '{64'h2000, 64'h2001, 64'h2200, 64'h2201, 64'h2300,
                  64'h2301, 64'h2400, 64'h2401, 64'h2100, 64'h2101},
                '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1});
        for (int k = 1; k < 10 && k < log_q.size(); k++)
            chk("rr_spacing", 64'(log_q[k].cyc - log_q[k-1].cyc), (k % 2 == 0) ? 64'd2 : 64'd1);

        // Port 2 requests while port 1 is mid-packet: no interleave
        do_reset();
        fork
            send_pkt(1, 4, 64'h3000);
            begin wait_cyc(3); send_pkt(2, 2, 64'h3100); end
        join
        wait_cyc(4);
        chk_log("nointlv", '{1, 1, 1, 1, 2, 2},
                '{64'h3000, 64'h3001, 64'h3002, 64'h3003, 64'h3100, 64'h3101},
                '{0, 0, 0, 1, 0, 1});

        // 100-beat packet from port 3 under random master stalls
        do_reset();
        rnd_ready = 1'b1;
        send_pkt(3, 100, 64'h4000);
        w = 0;
        while (log_q.size() < 100 && w < 2000) begin
            wait_cyc(1);
            w++;
        end
        rnd_ready = 1'b0;
        M_AXIS_tready = 1'b1;
        wait_cyc(2);
        chk("stall_count", 64'(log_q.size()), 64'd100);
        for (int i = 0; i < 100 && i < log_q.size(); i++) begin
            chk("stall_tid", 64'(log_q[i].b.id), 64'd3);
            chk("stall_tdata", log_q[i].b.data, 64'h4000 + 64'(i));
            chk("stall_tlast", 64'(log_q[i].b.last), 64'(i == 99));
        end

        // Reset mid-packet, then ports 1 and 2 race: port 1 wins
        do_reset();
        fork
            send_pkt(2, 5, 64'h5000);
            begin
                wait_cyc(3);
                #2;
                chk("midrst_pre_valid", 64'(M_AXIS_tvalid), 64'd1);
                abort   = 1'b1;
                aresetn = 1'b0;
                #1;
                chk("midrst_m_tvalid", 64'(M_AXIS_tvalid), 64'd0);
                chk("midrst_s_tready", 64'(S_AXIS_tready), 64'd0);
                chk("midrst_m_tdata",  M_AXIS_tdata, 64'd0);
            end
        join
        abort = 1'b0;
        wait_cyc(2);
        aresetn = 1'b1;
        log_q.delete();
        fork
            send_pkt(1, 1, 64'h5100);
            send_pkt(2, 1, 64'h5200);
        join
        wait_cyc(4);
        chk_log("postrst", '{1, 2}, '{64'h5100, 64'h5200}, '{1, 1});

        // One-beat packet held by master back-pressure, then released
        do_reset();
        M_AXIS_tready = 1'b0;
        send_pkt(0, 1, 64'h6000);
        wait_cyc(5);
        chk("held_m_tvalid", 64'(M_AXIS_tvalid), 64'd1);
        chk("held_m_tdata",  M_AXIS_tdata, 64'h6000);
        chk("held_m_tlast",  64'(M_AXIS_tlast), 64'd1);
        chk("held_s_tready", 64'(S_AXIS_tready), 64'd0);
        M_AXIS_tready = 1'b1;
        wait_cyc(2);
        chk("held_drained", 64'(M_AXIS_tvalid), 64'd0);
        chk_log("held", '{0}, '{64'h6000}, '{1});
        t0 = cyc;
        send_pkt(1, 1, 64'h6100);
        wait_cyc(3);
        chk("rearb_count", 64'(log_q.size()), 64'd2);
        if (log_q.size() > 1) chk("rearb_latency", 64'(log_q[1].cyc - t0), 64'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule

`default_nettype wire
